// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with one-entry skid buffer, redirect squash and IF/ID register
package rv32i_pkg;
   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_FENCE  = 7'b0001111,
      OP_IMM    = 7'b0010011,
      OP_AUIPC  = 7'b0010111,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111,
      OP_SYSTEM = 7'b1110011
   } rv32i_opcode_t;
endpackage

module fetch_stage
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0060,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic          clk,
   input  logic          rst,
   output logic          inst_read,
   output logic [31:0]   inst_addr,
   input  logic [31:0]   inst_rdata,
   input  logic          inst_resp,
   input  logic          id_stall,
   input  logic          redirect,
   input  logic [31:0]   redirect_target,
   output logic          id_valid,
   output logic [31:0]   id_pc,
   output logic [31:0]   id_instr,
   output rv32i_opcode_t id_opcode,
   output logic [2:0]    id_funct3,
   output logic [6:0]    id_funct7
);
   typedef enum logic [1:0] {FETCH, HOLD, SQUASH} state_t;
   state_t      state_q;
   logic [31:0] pc_q, pend_q, skid_q, id_pc_q, id_instr_q, tgt_d;
   logic        id_valid_q, accept;
   assign accept    = !id_valid_q || !id_stall;
   assign tgt_d     = {redirect_target[31:2], 2'b00};
   assign inst_read = !rst && state_q != HOLD;
   assign inst_addr = pc_q;
   assign id_valid  = id_valid_q;
   assign id_pc     = id_pc_q;
   assign id_instr  = id_instr_q;
   assign id_opcode = rv32i_opcode_t'(id_instr_q[6:0]);
   assign id_funct3 = id_instr_q[14:12];
   assign id_funct7 = id_instr_q[31:25];
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         pend_q     <= '0;
         skid_q     <= '0;
         id_valid_q <= 1'b0;
         id_pc_q    <= '0;
         id_instr_q <= NOP_INSTR;
      end else if (redirect) begin
         id_valid_q <= 1'b0;
         id_instr_q <= NOP_INSTR;
         // an unanswered request must still complete, so park the target until it does
         if (state_q != HOLD && !inst_resp) begin
            pend_q  <= tgt_d;
            state_q <= SQUASH;
         end else begin
            pc_q    <= tgt_d;
            state_q <= FETCH;
         end
      end else begin
         case (state_q)
            FETCH: begin
               if (inst_resp) begin
                  pc_q <= pc_q + 32'd4;
                  if (accept) begin
                     id_valid_q <= 1'b1;
                     id_pc_q    <= pc_q;
                     id_instr_q <= inst_rdata;
                  end else begin
                     skid_q  <= inst_rdata;
                     state_q <= HOLD;
                  end
               end else if (accept) begin
                  id_valid_q <= 1'b0;
                  id_instr_q <= NOP_INSTR;
               end
            end
            HOLD: begin
               if (accept) begin
                  id_valid_q <= 1'b1;
                  id_pc_q    <= pc_q - 32'd4;
                  id_instr_q <= skid_q;
                  state_q    <= FETCH;
               end
            end
            SQUASH: begin
               if (inst_resp) begin
                  pc_q    <= pend_q;
                  state_q <= FETCH;
               end
            end
            default: state_q <= FETCH;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed plan scenarios plus randomized stall/redirect/latency run against a program-order model
module tb_fetch_stage;
   import rv32i_pkg::*;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic          clk = 1'b0, rst = 1'b1;
   logic          inst_read, inst_resp, id_valid;
   logic          id_stall = 1'b0, redirect = 1'b0;
   logic [31:0]   inst_addr, inst_rdata, id_pc, id_instr;
   logic [31:0]   redirect_target = '0;
   rv32i_opcode_t id_opcode;
   logic [2:0]    id_funct3;
   logic [6:0]    id_funct7;
   int            errors = 0, checks = 0;
   int            lat_fixed = 0, lat_q = 0, wait_q = 0, idle = 0;
   bit            rand_lat = 1'b0, force_resp = 1'b0;
   logic [31:0]   exp_pc = 32'h60, prev_addr = '0, prev_pc = '0, prev_instr = '0, ew, w;
   bit            prev_wait = 1'b0, prev_hold = 1'b0, prev_redir = 1'b0;

   fetch_stage dut (
      .clk(clk), .rst(rst), .inst_read(inst_read), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_resp(inst_resp), .id_stall(id_stall),
      .redirect(redirect), .redirect_target(redirect_target), .id_valid(id_valid),
      .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode),
      .id_funct3(id_funct3), .id_funct7(id_funct7)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic sample;
      @(negedge clk);
   endtask

   task automatic do_reset(input int lat);
      tick;
      rst = 1'b1;
      id_stall = 1'b0;
      redirect = 1'b0;
      lat_fixed = lat;
      tick;
      tick;
      rst = 1'b0;
   endtask

   // memory: answers after a per-request latency, forgets the request when read drops or on reset
   assign inst_resp  = force_resp || (inst_read && wait_q >= (rand_lat ? lat_q : lat_fixed));
   assign inst_rdata = force_resp ? 32'hDEAD_BEEF : word(inst_addr);
   always @(posedge clk or posedge rst) begin
      if (rst) wait_q <= 0;
      else if (!inst_read || inst_resp) begin
         wait_q <= 0;
         if (inst_resp) lat_q <= int'($urandom_range(0, 2));
      end else wait_q <= wait_q + 1;
   end

   // program-order model: each consumed instruction is the next sequential PC, restarting at every redirect
   always @(negedge clk) begin
      if (rst) begin
         exp_pc = 32'h60;
         prev_wait = 1'b0;
         prev_hold = 1'b0;
         prev_redir = 1'b0;
         idle = 0;
      end else begin
         if (prev_wait) begin
            chk("addr_stable", inst_addr, prev_addr);
            chk("read_held", 32'(inst_read), 1);
         end
         if (prev_hold) begin
            chk("stall_valid", 32'(id_valid), 1);
            chk("stall_pc", id_pc, prev_pc);
            chk("stall_instr", id_instr, prev_instr);
         end
         if (prev_redir) chk("flush", 32'(id_valid), 0);
         if (id_valid) begin
            ew = word(exp_pc);
            chk("seq_pc", id_pc, exp_pc);
            chk("seq_instr", id_instr, ew);
            chk("opcode", 32'(id_opcode), {25'b0, ew[6:0]});
            chk("funct3", 32'(id_funct3), {29'b0, ew[14:12]});
            chk("funct7", 32'(id_funct7), {25'b0, ew[31:25]});
         end else chk("nop", id_instr, NOP);
         idle = (id_valid || redirect) ? 0 : idle + 1;
         chk("progress", 32'(idle > 11), 0);
         prev_wait = inst_read && !inst_resp;
         prev_addr = inst_addr;
         prev_hold = id_valid && id_stall && !redirect;
         prev_pc = id_pc;
         prev_instr = id_instr;
         prev_redir = redirect;
         if (redirect) exp_pc = {redirect_target[31:2], 2'b00};
         else if (id_valid && !id_stall) exp_pc = exp_pc + 32'd4;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not reach its end");
      $fatal(1);
   end

   initial begin
      sample;
      chk("rst_read", 32'(inst_read), 0);
      chk("rst_valid", 32'(id_valid), 0);
      chk("rst_idpc", id_pc, 0);
      chk("rst_instr", id_instr, NOP);
      // zero-latency streaming, then a 3-cycle stall into the skid buffer
      do_reset(0);
      sample;
      chk("t1_read", 32'(inst_read), 1);
      chk("t1_addr0", inst_addr, 'h60);
      tick; sample;
      w = word(32'h60);
      chk("t1_addr1", inst_addr, 'h64);
      chk("t1_idpc0", id_pc, 'h60);
      chk("t1_valid", 32'(id_valid), 1);
      chk("t1_opcode", 32'(id_opcode), {25'b0, w[6:0]});
      tick; id_stall = 1'b1; sample;
      chk("t1_addr2", inst_addr, 'h68);
      chk("t1_idpc1", id_pc, 'h64);
      repeat (2) begin
         tick; sample;
         chk("t2_hold_read", 32'(inst_read), 0);
         chk("t2_hold_pc", id_pc, 'h64);
         chk("t2_hold_instr", id_instr, word(32'h64));
      end
      tick; id_stall = 1'b0; sample;
      chk("t2_rel_read", 32'(inst_read), 0);
      chk("t2_rel_pc", id_pc, 'h64);
      tick; sample;
      chk("t2_pc68", id_pc, 'h68);
      chk("t2_read", 32'(inst_read), 1);
      chk("t2_addr6c", inst_addr, 'h6C);
      tick; sample;
      chk("t2_pc6c", id_pc, 'h6C);
      // 2-cycle memory, redirect while the first request is outstanding
      do_reset(2);
      sample;
      chk("t3_addr0", inst_addr, 'h60);
      tick; redirect = 1'b1; redirect_target = 'h203; sample;
      chk("t3_addr1", inst_addr, 'h60);
      chk("t3_noresp", 32'(inst_resp), 0);
      tick; redirect = 1'b0; sample;
      chk("t3_addr2", inst_addr, 'h60);
      chk("t3_resp", 32'(inst_resp), 1);
      tick; sample;
      chk("t3_dropped", 32'(id_valid), 0);
      chk("t3_newaddr", inst_addr, 'h200);
      repeat (3) tick;
      sample;
      chk("t3_valid", 32'(id_valid), 1);
      chk("t3_idpc", id_pc, 'h200);
      // redirect beats stall
      do_reset(0);
      sample;
      tick; id_stall = 1'b1; redirect = 1'b1; redirect_target = 'h500; sample;
      chk("t4_valid_pre", 32'(id_valid), 1);
      tick; redirect = 1'b0; sample;
      chk("t4_flush", 32'(id_valid), 0);
      chk("t4_addr", inst_addr, 'h500);
      tick; sample;
      chk("t4_valid", 32'(id_valid), 1);
      chk("t4_idpc", id_pc, 'h500);
      // two redirects while squashing, the last one wins
      do_reset(3);
      sample;
      tick; redirect = 1'b1; redirect_target = 'h300; sample;
      tick; redirect_target = 'h400; sample;
      chk("t5_addr_hold", inst_addr, 'h60);
      tick; redirect = 1'b0; sample;
      chk("t5_resp", 32'(inst_resp), 1);
      chk("t5_addr_old", inst_addr, 'h60);
      tick; sample;
      chk("t5_addr_new", inst_addr, 'h400);
      // PC wraps past the top of the address space
      do_reset(0);
      sample;
      tick; redirect = 1'b1; redirect_target = 32'hFFFF_FFFA; sample;
      tick; redirect = 1'b0; sample;
      chk("t7_addr_f8", inst_addr, 32'hFFFF_FFF8);
      tick; sample;
      chk("t7_addr_fc", inst_addr, 32'hFFFF_FFFC);
      chk("t7_idpc_f8", id_pc, 32'hFFFF_FFF8);
      tick; sample;
      chk("t7_addr_wrap", inst_addr, 32'h0);
      chk("t7_idpc_fc", id_pc, 32'hFFFF_FFFC);
      // reset with a buffered word and a stray response during reset
      do_reset(0);
      sample;
      tick; id_stall = 1'b1; sample;
      tick; sample;
      chk("t6_hold_read", 32'(inst_read), 0);
      tick; rst = 1'b1; id_stall = 1'b0; force_resp = 1'b1; #1;
      chk("t6_rst_read", 32'(inst_read), 0);
      chk("t6_rst_valid", 32'(id_valid), 0);
      chk("t6_rst_idpc", id_pc, 0);
      chk("t6_rst_instr", id_instr, NOP);
      tick; sample;
      chk("t6_rst_valid2", 32'(id_valid), 0);
      tick; force_resp = 1'b0; lat_fixed = 1; rst = 1'b0; sample;
      chk("t6_read", 32'(inst_read), 1);
      chk("t6_addr", inst_addr, 'h60);
      chk("t6_valid0", 32'(id_valid), 0);
      tick; sample;
      chk("t6_resp", 32'(inst_resp), 1);
      tick; sample;
      chk("t6_valid", 32'(id_valid), 1);
      chk("t6_idpc", id_pc, 'h60);
      // random stalls, redirects, latencies and occasional resets
      do_reset(0);
      rand_lat = 1'b1;
      repeat (3000) begin
         tick;
         id_stall = ($urandom % 4) == 0;
         redirect = ($urandom % 16) == 0;
         redirect_target = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
         rst = ($urandom % 500) == 0;
      end
      tick;
      rst = 1'b0;
      redirect = 1'b0;
      id_stall = 1'b0;
      repeat (4) tick;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
